enc8to3_seq: RTL and testbench
==============================

ENC8TO3_SEQ -- requirements
Module: enc8to3_seq

Interface
REQ-001 Parameter MSB_FIRST, default 1, emission order: 1 = highest set bit first, 0 = lowest set bit first.
REQ-002 Clock  input  1  system clock; all state changes on rising edge.
REQ-003 Reset  input  1  asynchronous, active-high reset.
REQ-004 W  input  8  request vector; any number of bits may be set.
REQ-005 En  input  1  load strobe; samples W when the block is idle.
REQ-006 Ready  input  1  downstream accepts the current code.
REQ-007 Y  output  3  binary index of the bit currently presented.
REQ-008 Valid  output  1  Y is a valid code.
REQ-009 Last  output  1  current code is the final one of the captured vector.
REQ-010 Busy  output  1  block holds an unfinished vector; En is ignored.
REQ-011 Count  output  4  number of set bits still pending, 0..8.
REQ-012 Zero  output  1  one-cycle pulse: an all-zero vector was loaded.

Function
REQ-013 Block SHALL hold an 8-bit pending register P and a two-state FSM: IDLE, EMIT.
REQ-014 IDLE: Valid=0, Busy=0, Last=0, Y=0, Count=0.
REQ-015 IDLE, En=1, W!=0: SHALL load P<=W and enter EMIT at that edge; Valid SHALL be 1 in the next cycle (latency one clock).
REQ-016 IDLE, En=1, W=0: SHALL stay IDLE and assert Zero for exactly the following cycle; P unchanged (zero).
REQ-017 EMIT: Valid=1, Busy=1; Y = index of highest set bit of P if MSB_FIRST=1, else lowest set bit.
REQ-018 Count SHALL equal the population count of P; Last SHALL be 1 iff Count=1.
REQ-019 Handshake: a code is transferred on any rising edge with Valid=1 and Ready=1; that bit of P SHALL be cleared at that edge.
REQ-020 Ready=0 in EMIT: P, Y, Last, Count SHALL hold unchanged for any number of cycles.
REQ-021 Transfer with Last=1: FSM SHALL return to IDLE at that edge; Valid SHALL be 0 the next cycle.
REQ-022 En while in EMIT (including the Last transfer edge) SHALL be ignored; W is not sampled; no Zero pulse.
REQ-023 Ready while Valid=0 SHALL have no effect.
REQ-024 Y, Valid, Last, Busy, Count SHALL be decoded from registered state only; no combinational path from W, En or Ready to any output.
REQ-025 Vector 8'hFF SHALL yield eight transfers, Count 8 down to 1, codes 7..0 (MSB_FIRST=1) or 0..7 (MSB_FIRST=0).
REQ-026 Minimum spacing between loads: one IDLE cycle after the Last transfer edge.

Reset
REQ-027 Reset=1 SHALL immediately, without a clock edge, force FSM=IDLE, P=0, Zero=0, and thus Y=0, Valid=0, Last=0, Busy=0, Count=0.
REQ-028 Reset asserted mid-EMIT SHALL discard all pending bits; no further transfers after release.
REQ-029 First load SHALL be accepted on the first rising edge with Reset=0 and En=1.

Verification
REQ-030 MSB_FIRST=1, W=8'b1010_0100, En pulse, Ready=1 -> Y=7,5,2 on three consecutive cycles; Count=3,2,1; Last only on Y=2; Valid=0 after.
REQ-031 MSB_FIRST=0, same W, Ready=1 -> Y=2,5,7; Last on Y=7.
REQ-032 W=8'h10 loaded, Ready=0 for 5 cycles then 1 -> Y=4, Valid=1, Last=1, Count=1 held 5 cycles; single transfer; then IDLE.
REQ-033 W=8'h00 with En=1 -> Zero=1 for one cycle, Valid stays 0, Busy stays 0.
REQ-034 W=8'hFF loaded, Ready=1, En=1 with W=8'h01 on every EMIT cycle -> exactly 8 transfers (7..0), second vector not loaded.
REQ-035 W=8'hC3 loaded, Reset asserted after second transfer (between clock edges) -> outputs zero at once; after release no Valid until new En.

Source files
------------

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 priority encoder: captures a request vector and emits the index of
// every set bit, one per ready/valid handshake, highest-first or lowest-first.
module enc8to3_seq #(
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] w_i,
    input  logic       en_i,
    input  logic       ready_i,
    output logic [2:0] y_o,
    output logic       valid_o,
    output logic       last_o,
    output logic       busy_o,
    output logic [3:0] count_o,
    output logic       zero_o
);

    typedef enum logic {StIdle, StEmit} state_e;

    state_e     state_q, state_d;
    logic [7:0] p_q, p_d;
    logic       zero_q, zero_d;
    logic [2:0] sel_idx;
    logic [3:0] pop;

    // Later matches overwrite earlier ones, so scan direction sets the priority.
    always_comb begin
        sel_idx = '0;
        if (MSB_FIRST) begin
            for (int i = 0; i < 8; i++) begin
                if (p_q[i]) sel_idx = 3'(i);
            end
        end else begin
            for (int i = 7; i >= 0; i--) begin
                if (p_q[i]) sel_idx = 3'(i);
            end
        end
    end

    always_comb begin
        pop = '0;
        for (int i = 0; i < 8; i++) begin
            pop = pop + {3'b000, p_q[i]};
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            p_q     <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            zero_q  <= zero_d;
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        zero_d  = 1'b0;
        case (state_q)
            StIdle: begin
                if (en_i) begin
                    if (w_i != 8'h00) begin
                        p_d     = w_i;
                        state_d = StEmit;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            StEmit: begin
                if (ready_i) begin
                    p_d[sel_idx] = 1'b0;
                    if (pop == 4'd1) state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        y_o     = '0;
        valid_o = 1'b0;
        last_o  = 1'b0;
        busy_o  = 1'b0;
        count_o = '0;
        zero_o  = zero_q;
        if (state_q == StEmit) begin
            y_o     = sel_idx;
            valid_o = 1'b1;
            busy_o  = 1'b1;
            count_o = pop;
            last_o  = (pop == 4'd1);
        end
    end

endmodule

// File: tb/tb_enc8to3_seq.sv
// Bench for enc8to3_seq: both emission orders side by side against a queue-based model.
module tb_enc8to3_seq;

    logic       clk = 1'b0;
    logic       rst_i = 1'b0;
    logic [7:0] w_i = '0;
    logic       en_i = 1'b0;
    logic       ready_i = 1'b0;

    logic [2:0] y_m, y_l;
    logic       valid_m, valid_l, last_m, last_l, busy_m, busy_l, zero_m, zero_l;
    logic [3:0] count_m, count_l;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    enc8to3_seq #(.MSB_FIRST(1'b1)) dut_m (
        .clk_i(clk), .rst_i(rst_i), .w_i(w_i), .en_i(en_i), .ready_i(ready_i),
        .y_o(y_m), .valid_o(valid_m), .last_o(last_m), .busy_o(busy_m),
        .count_o(count_m), .zero_o(zero_m)
    );

    enc8to3_seq #(.MSB_FIRST(1'b0)) dut_l (
        .clk_i(clk), .rst_i(rst_i), .w_i(w_i), .en_i(en_i), .ready_i(ready_i),
        .y_o(y_l), .valid_o(valid_l), .last_o(last_l), .busy_o(busy_l),
        .count_o(count_l), .zero_o(zero_l)
    );

    // {y, valid, last, busy, count, zero}
    wire [10:0] obs_m = {y_m, valid_m, last_m, busy_m, count_m, zero_m};
    wire [10:0] obs_l = {y_l, valid_l, last_l, busy_l, count_l, zero_l};

    // Pending bit indices in the order each instance should present them.
    int   qm[$];
    int   ql[$];
    logic zero_e = 1'b0;

    function automatic logic [10:0] exp_vec(input bit msb);
        int         n = qm.size();
        logic [2:0] y = '0;
        if (n > 0) y = msb ? 3'(qm[0]) : 3'(ql[0]);
        return {y, logic'(n > 0), logic'(n == 1), logic'(n > 0), 4'(n), zero_e};
    endfunction

    task automatic model_clear();
        qm.delete();
        ql.delete();
        zero_e = 1'b0;
    endtask

    task automatic model_edge(input logic [7:0] w, input logic en, input logic rdy);
        zero_e = 1'b0;
        if (qm.size() > 0) begin
            if (rdy) begin
                void'(qm.pop_front());
                void'(ql.pop_front());
            end
        end else if (en) begin
            if (w == 8'h00) begin
                zero_e = 1'b1;
            end else begin
                for (int i = 7; i >= 0; i--) if (w[i]) qm.push_back(i);
                for (int i = 0; i < 8; i++) if (w[i]) ql.push_back(i);
            end
        end
    endtask

    task automatic step(input logic [7:0] w, input logic en, input logic rdy);
        w_i = w;
        en_i = en;
        ready_i = rdy;
        @(posedge clk);
        model_edge(w, en, rdy);
        #1;
    endtask

    task automatic test_reset();
        #1 rst_i = 1'b1;
        #1;
        checks++;
        if (obs_m !== 11'd0) begin
            failures++;
            $display("FAIL reset_m: got %h want %h", obs_m, 11'd0);
        end
        checks++;
        if (obs_l !== 11'd0) begin
            failures++;
            $display("FAIL reset_l: got %h want %h", obs_l, 11'd0);
        end
        @(negedge clk);
        rst_i = 1'b0;
        model_clear();
    endtask

    task automatic test_zero_load();
        for (int c = 0; c < 3; c++) begin
            step(8'h00, c == 0, 1'b1);
            checks++;
            if (obs_m !== exp_vec(1'b1) || zero_m !== (c == 0)) begin
                failures++;
                $display("FAIL zero_m c%0d: got %h want %h", c, obs_m, exp_vec(1'b1));
            end
            checks++;
            if (obs_l !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL zero_l c%0d: got %h want %h", c, obs_l, exp_vec(1'b0));
            end
        end
    endtask

    task automatic test_vector_a4();
        int ym[3] = '{7, 5, 2};
        int yl[3] = '{2, 5, 7};
        step(8'b1010_0100, 1'b1, 1'b1);
        for (int c = 0; c < 4; c++) begin
            checks++;
            if (obs_m !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL a4_m c%0d: got %h want %h", c, obs_m, exp_vec(1'b1));
            end
            checks++;
            if (obs_l !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL a4_l c%0d: got %h want %h", c, obs_l, exp_vec(1'b0));
            end
            if (c < 3) begin
                checks++;
                if (y_m !== 3'(ym[c]) || y_l !== 3'(yl[c]) || count_m !== 4'(3 - c)
                    || last_m !== (c == 2) || last_l !== (c == 2)) begin
                    failures++;
                    $display("FAIL a4_seq c%0d: got y %0d/%0d cnt %0d want y %0d/%0d cnt %0d",
                             c, y_m, y_l, count_m, ym[c], yl[c], 3 - c);
                end
            end
            step(8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic test_hold();
        step(8'h10, 1'b1, 1'b0);
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (obs_m !== exp_vec(1'b1) || obs_m !== {3'd4, 1'b1, 1'b1, 1'b1, 4'd1, 1'b0}) begin
                failures++;
                $display("FAIL hold_m c%0d: got %h want %h", c, obs_m, exp_vec(1'b1));
            end
            // Inputs changing mid-cycle must not reach the outputs.
            ready_i = 1'b1;
            en_i = 1'b1;
            w_i = 8'hFF;
            #1;
            checks++;
            if (obs_l !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL hold_l c%0d: got %h want %h", c, obs_l, exp_vec(1'b0));
            end
            if (c < 4) step(8'h00, 1'b0, 1'b0);
        end
        step(8'h00, 1'b0, 1'b1);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (obs_m !== exp_vec(1'b1) || valid_m !== 1'b0) begin
                failures++;
                $display("FAIL hold_done c%0d: got %h want %h", c, obs_m, exp_vec(1'b1));
            end
            step(8'h00, 1'b0, 1'b1);
        end
    endtask

    task automatic test_ff_with_en();
        int xfers = 0;
        step(8'hFF, 1'b1, 1'b1);
        for (int c = 0; c < 9; c++) begin
            if (valid_m && y_m === 3'(7 - c) && count_m === 4'(8 - c)) xfers++;
            checks++;
            if (obs_m !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL ff_m c%0d: got %h want %h", c, obs_m, exp_vec(1'b1));
            end
            checks++;
            if (obs_l !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL ff_l c%0d: got %h want %h", c, obs_l, exp_vec(1'b0));
            end
            step(8'h01, c < 8, 1'b1);
        end
        checks++;
        if (xfers !== 8) begin
            failures++;
            $display("FAIL ff_transfers: got %0d want %0d", xfers, 8);
        end
    endtask

    task automatic test_reset_mid();
        step(8'hC3, 1'b1, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        step(8'h00, 1'b0, 1'b1);
        #2 rst_i = 1'b1;
        #1;
        model_clear();
        checks++;
        if (obs_m !== 11'd0 || obs_l !== 11'd0) begin
            failures++;
            $display("FAIL rst_mid: got %h/%h want %h", obs_m, obs_l, 11'd0);
        end
        @(negedge clk);
        rst_i = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step(8'hC3, 1'b0, 1'b1);
            checks++;
            if (obs_m !== exp_vec(1'b1) || obs_l !== exp_vec(1'b0) || valid_m !== 1'b0) begin
                failures++;
                $display("FAIL rst_after c%0d: got %h/%h want %h", c, obs_m, obs_l,
                         exp_vec(1'b1));
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            logic [7:0] w;
            w = ($urandom_range(0, 5) == 0) ? 8'h00 : 8'($urandom);
            step(w, 1'($urandom), ($urandom_range(0, 3) != 0));
            checks++;
            if (obs_m !== exp_vec(1'b1)) begin
                failures++;
                $display("FAIL rand_m c%0d: got %h want %h", c, obs_m, exp_vec(1'b1));
            end
            checks++;
            if (obs_l !== exp_vec(1'b0)) begin
                failures++;
                $display("FAIL rand_l c%0d: got %h want %h", c, obs_l, exp_vec(1'b0));
            end
        end
    endtask

    initial begin
        test_reset();
        test_zero_load();
        test_vector_a4();
        test_hold();
        test_ff_with_en();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
